// File: rtl/mem_seq_pkg.sv
// rtl/mem_seq_pkg.sv - shared state encoding and constants for mem_sequencer
//
// Purpose : sequencer state type and the default bus timeout.
// Contents: state_t  - FETCH/EXEC/DATA/WB encoding
//           TIMEOUT_DEFAULT - default bus wait limit in cycles
package mem_seq_pkg;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_DATA  = 2'd2,
      ST_WB    = 2'd3
   } state_t;

   localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_sequencer_wait_timer.sv
// rtl/mem_sequencer_wait_timer.sv - bus wait-state counter with expiry detect
//
// Purpose : counts bus request cycles without ack; flags the cycle in which
//           the count would reach the limit.
// Ports   : clk, rst       - clock, async active-high reset
//           i_clear        - zero the counter (highest priority)
//           i_count        - increment the counter this cycle
//           i_limit [TW]   - number of counted cycles allowed
//           o_expired      - high in the counting cycle that reaches i_limit
module wait_timer #(
   parameter int TW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_clear,
   input  logic          i_count,
   input  logic [TW-1:0] i_limit,
   output logic          o_expired
);

   logic [TW-1:0] r_count;
   logic          w_last;

   // The current cycle is the limit-th counted cycle when the count already
   // holds limit-1; abort happens on that edge rather than one cycle later.
   assign w_last    = (r_count == (i_limit - TW'(1)));
   assign o_expired = i_count && w_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_count) begin
         r_count <= r_count + TW'(1);
      end
   end

endmodule

// File: rtl/mem_sequencer.sv
// rtl/mem_sequencer.sv - multicycle fetch/load/store sequencer on a shared bus
//
// Purpose : sequences instruction fetch and data access onto one memory bus,
//           stalls the PC, latches instr/readdata and emits a commit strobe.
// Ports   : clk, reset                        - clock, async active-high reset
//           pc                                - fetch address
//           dmem_req, dmem_we                 - data access request / store
//           dmem_addr, dmem_wdata             - data address / store data
//           instr, readdata                   - latched fetch / load data
//           pc_stall, commit                  - PC hold, retire strobe
//           bus_req, bus_we, bus_addr,
//           bus_wdata, bus_rdata, bus_ack     - memory bus master side
//           bus_err                           - sticky timeout flag
module mem_sequencer
   import mem_seq_pkg::*;
#(
   parameter int dwidth  = 32,
   parameter int TIMEOUT = TIMEOUT_DEFAULT,
   parameter int TW      = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [dwidth-1:0] pc,
   input  logic              dmem_req,
   input  logic              dmem_we,
   input  logic [dwidth-1:0] dmem_addr,
   input  logic [dwidth-1:0] dmem_wdata,
   output logic [dwidth-1:0] instr,
   output logic [dwidth-1:0] readdata,
   output logic              pc_stall,
   output logic              commit,
   output logic              bus_req,
   output logic              bus_we,
   output logic [dwidth-1:0] bus_addr,
   output logic [dwidth-1:0] bus_wdata,
   input  logic [dwidth-1:0] bus_rdata,
   input  logic              bus_ack,
   output logic              bus_err
);

   state_t            r_state;
   logic [dwidth-1:0] r_instr;
   logic [dwidth-1:0] r_readdata;
   logic              r_err;

   logic              w_in_req;
   logic              w_ack;
   logic              w_expired;

   assign w_in_req = (r_state == ST_FETCH) || (r_state == ST_DATA);
   // Reset gates the request combinationally so it drops in the reset cycle.
   assign bus_req  = w_in_req && !reset;
   // An ack outside a request state is a stray and is ignored.
   assign w_ack    = bus_ack && w_in_req;

   assign commit    = ((r_state == ST_EXEC) && !dmem_req) || (r_state == ST_WB);
   assign pc_stall  = !commit;
   assign bus_we    = (r_state == ST_DATA) && dmem_we;
   assign bus_addr  = (r_state == ST_DATA) ? dmem_addr : pc;
   assign bus_wdata = dmem_wdata;

   assign instr    = r_instr;
   assign readdata = r_readdata;
   assign bus_err  = r_err;

   // Counter is idle (cleared) in EXEC/WB, so it enters FETCH/DATA at zero.
   wait_timer #(
      .TW (TW)
   ) u_wait_timer (
      .clk       (clk),
      .rst       (reset),
      .i_clear   (!w_in_req || w_ack || w_expired),
      .i_count   (w_in_req && !bus_ack),
      .i_limit   (TW'(TIMEOUT)),
      .o_expired (w_expired)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_FETCH;
         r_instr    <= '0;
         r_readdata <= '0;
         r_err      <= 1'b0;
      end else begin
         case (r_state)
            ST_FETCH: begin
               if (w_ack) begin
                  r_instr <= bus_rdata;
                  r_state <= ST_EXEC;
               end else if (w_expired) begin
                  // Aborted fetch executes as a NOP.
                  r_instr <= '0;
                  r_err   <= 1'b1;
                  r_state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               r_state <= dmem_req ? ST_DATA : ST_FETCH;
            end
            ST_DATA: begin
               if (w_ack) begin
                  if (!dmem_we) r_readdata <= bus_rdata;
                  r_state <= ST_WB;
               end else if (w_expired) begin
                  if (!dmem_we) r_readdata <= '0;
                  r_err   <= 1'b1;
                  r_state <= ST_WB;
               end
            end
            ST_WB: begin
               r_state <= ST_FETCH;
            end
            default: r_state <= ST_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_sequencer.sv
// tb/tb_mem_sequencer.sv - directed self-checking bench for mem_sequencer
module tb_mem_sequencer;

   logic        clk;
   logic        reset;
   logic [31:0] pc;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [31:0] instr;
   logic [31:0] readdata;
   logic        pc_stall;
   logic        commit;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ack;
   logic        bus_err;

   int n_checks = 0;
   int n_fail   = 0;
   int n_commit;

   mem_sequencer #(
      .dwidth  (32),
      .TIMEOUT (4),
      .TW      (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .pc         (pc),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .instr      (instr),
      .readdata   (readdata),
      .pc_stall   (pc_stall),
      .commit     (commit),
      .bus_req    (bus_req),
      .bus_we     (bus_we),
      .bus_addr   (bus_addr),
      .bus_wdata  (bus_wdata),
      .bus_rdata  (bus_rdata),
      .bus_ack    (bus_ack),
      .bus_err    (bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset      = 1'b1;
      pc         = 32'h0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      dmem_addr  = 32'h0;
      dmem_wdata = 32'h0;
      bus_rdata  = 32'h0;
      bus_ack    = 1'b0;
      #1;
      chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_readdata", readdata, 32'h0);
      chk("rst_bus_err", {31'b0, bus_err}, 32'd0);
      chk("rst_pc_stall", {31'b0, pc_stall}, 32'd1);
      chk("rst_commit", {31'b0, commit}, 32'd0);
      step();
      step();
      reset = 1'b0;
      #1;

      // 1: non-memory instruction, zero wait
      bus_ack = 1'b1; bus_rdata = 32'h02328020; #1;
      chk("t1_fetch_req", {31'b0, bus_req}, 32'd1);
      chk("t1_fetch_addr", bus_addr, 32'h0);
      chk("t1_fetch_we", {31'b0, bus_we}, 32'd0);
      chk("t1_fetch_commit", {31'b0, commit}, 32'd0);
      step();
      bus_ack = 1'b0; #1;
      chk("t1_instr", instr, 32'h02328020);
      chk("t1_exec_commit", {31'b0, commit}, 32'd1);
      chk("t1_exec_stall", {31'b0, pc_stall}, 32'd0);
      chk("t1_exec_req", {31'b0, bus_req}, 32'd0);
      step();
      chk("t1_back_fetch", {31'b0, bus_req}, 32'd1);

      // 2: load with 3 wait states, ack lands on the 4th (timeout) DATA cycle
      n_commit = 0;
      pc = 32'h4; bus_ack = 1'b1; bus_rdata = 32'h8C080100; #1;
      chk("t2_fetch_addr", bus_addr, 32'h4);
      n_commit += int'(commit);
      step();
      bus_ack = 1'b0; dmem_req = 1'b1; dmem_we = 1'b0; dmem_addr = 32'h100; #1;
      chk("t2_instr", instr, 32'h8C080100);
      chk("t2_exec_commit", {31'b0, commit}, 32'd0);
      n_commit += int'(commit);
      step();
      for (int k = 0; k < 4; k++) begin
         bus_ack = (k == 3); bus_rdata = 32'hDEADBEEF; #1;
         chk($sformatf("t2_data%0d_req", k), {31'b0, bus_req}, 32'd1);
         chk($sformatf("t2_data%0d_we", k), {31'b0, bus_we}, 32'd0);
         chk($sformatf("t2_data%0d_addr", k), bus_addr, 32'h100);
         n_commit += int'(commit);
         step();
      end
      bus_ack = 1'b0; #1;
      chk("t2_readdata", readdata, 32'hDEADBEEF);
      chk("t2_wb_commit", {31'b0, commit}, 32'd1);
      chk("t2_wb_req", {31'b0, bus_req}, 32'd0);
      n_commit += int'(commit);
      step();
      dmem_req = 1'b0; #1;
      chk("t2_fetch_again", {31'b0, bus_req}, 32'd1);
      chk("t2_commit_count", n_commit, 32'd1);
      chk("t2_no_err", {31'b0, bus_err}, 32'd0);

      // 3: store zero wait, plus stray acks in EXEC and WB
      pc = 32'h8; bus_ack = 1'b1; bus_rdata = 32'hAC0A0200; #1;
      step();
      dmem_req = 1'b1; dmem_we = 1'b1; dmem_addr = 32'h200; dmem_wdata = 32'h12345678;
      bus_ack = 1'b1; bus_rdata = 32'h77777777; #1;
      chk("t3_exec_commit", {31'b0, commit}, 32'd0);
      chk("t3_exec_req", {31'b0, bus_req}, 32'd0);
      step();
      bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF; #1;
      chk("t3_instr_after_stray", instr, 32'hAC0A0200);
      chk("t3_data_we", {31'b0, bus_we}, 32'd1);
      chk("t3_data_addr", bus_addr, 32'h200);
      chk("t3_data_wdata", bus_wdata, 32'h12345678);
      chk("t3_data_commit", {31'b0, commit}, 32'd0);
      step();
      bus_ack = 1'b1; bus_rdata = 32'h55555555; #1;
      chk("t3_wb_readdata", readdata, 32'hDEADBEEF);
      chk("t3_wb_commit", {31'b0, commit}, 32'd1);
      step();
      bus_ack = 1'b0; dmem_req = 1'b0; dmem_we = 1'b0; #1;
      chk("t3_fetch_req", {31'b0, bus_req}, 32'd1);
      chk("t3_readdata_kept", readdata, 32'hDEADBEEF);
      chk("t3_instr_kept", instr, 32'hAC0A0200);

      // 6b: fetch ack on the exact timeout cycle wins
      pc = 32'hC;
      for (int k = 0; k < 4; k++) begin
         bus_ack = (k == 3); bus_rdata = 32'h01234567; #1;
         step();
      end
      bus_ack = 1'b0; #1;
      chk("t6_instr", instr, 32'h01234567);
      chk("t6_no_err", {31'b0, bus_err}, 32'd0);
      chk("t6_exec_commit", {31'b0, commit}, 32'd1);
      step();

      // 4: fetch timeout, never acked
      pc = 32'h10; bus_ack = 1'b0; #1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("t4_wait%0d_req", k), {31'b0, bus_req}, 32'd1);
         chk($sformatf("t4_wait%0d_err", k), {31'b0, bus_err}, 32'd0);
         step();
      end
      chk("t4_err", {31'b0, bus_err}, 32'd1);
      chk("t4_instr_nop", instr, 32'h0);
      chk("t4_exec_commit", {31'b0, commit}, 32'd1);
      step();
      bus_ack = 1'b1; bus_rdata = 32'h02328020; #1;
      step();
      bus_ack = 1'b0; #1;
      chk("t4_good_instr", instr, 32'h02328020);
      chk("t4_err_sticky", {31'b0, bus_err}, 32'd1);
      step();

      // load timeout in DATA returns zero
      bus_ack = 1'b1; bus_rdata = 32'h8C080300; #1;
      step();
      bus_ack = 1'b0; dmem_req = 1'b1; dmem_we = 1'b0; dmem_addr = 32'h300; #1;
      step();
      for (int k = 0; k < 4; k++) step();
      chk("t4_load_abort_readdata", readdata, 32'h0);
      chk("t4_load_abort_commit", {31'b0, commit}, 32'd1);
      step();
      dmem_req = 1'b0; #1;

      // 5: reset in the middle of a DATA wait
      pc = 32'h20; bus_ack = 1'b1; bus_rdata = 32'h8C080400; #1;
      step();
      bus_ack = 1'b0; dmem_req = 1'b1; dmem_addr = 32'h400; #1;
      step();
      chk("t5_data_req", {31'b0, bus_req}, 32'd1);
      step();
      reset = 1'b1; #1;
      chk("t5_rst_req", {31'b0, bus_req}, 32'd0);
      chk("t5_rst_instr", instr, 32'h0);
      chk("t5_rst_readdata", readdata, 32'h0);
      chk("t5_rst_err", {31'b0, bus_err}, 32'd0);
      step();
      reset = 1'b0; dmem_req = 1'b0; #1;
      chk("t5_resume_req", {31'b0, bus_req}, 32'd1);
      chk("t5_resume_addr", bus_addr, 32'h20);
      chk("t5_resume_we", {31'b0, bus_we}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
